mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Parametrised multi-cycle load/store unit for the MEM stage. It accepts one load or store at a time from the pipeline over a valid/ready handshake and drives the word-organised external memory with byte enables. Misaligned halfword and word accesses that cross a word boundary are split into two bus beats. It returns a sign- or zero-extended writeback value tagged with the destination register.

## Interface
- ADDR_W, 18: width of the byte address from EX.
- EXT_ADDR_W, 16: width of the external word address; the word address is addr[EXT_ADDR_W+1:2].
- MISALIGN_SPLIT, 1: 1 splits boundary-crossing accesses into two beats; 0 rejects them with resp_err.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3.
  - 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu.
  - Other codes are treated as 010.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_rd  in  5  destination register for loads.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes the result.
- resp_data  out  32  extended load value; 0 for stores, errors, and rd==0.
- resp_rd  out  5  latched req_rd.
- resp_err  out  1  access was rejected as misaligned.
- ext_mem_addr  out  EXT_ADDR_W  word address.
- ext_mem_wdata  out  32  lane-aligned write data.
- ext_mem_be  out  4  byte-lane enables.
- ext_mem_read  out  1  read strobe.
- ext_mem_write  out  1  write strobe.
- ext_mem_rdata  in  32  read data; valid in the cycle ext_mem_ready is high.
- ext_mem_ready  in  1  beat complete.

## Operation
- Request fields:
  - Size is 1, 2 or 4 bytes, taken from funct3[1:0].
  - off = addr[1:0].
  - The access crosses a word boundary when off + size > 4.
- State machine: IDLE, BEAT0, BEAT1, RESP.
  - IDLE: req_ready = 1. On req_valid, latch all request fields.
    - If the access crosses and MISALIGN_SPLIT = 0, go to RESP with err = 1. No bus access is made.
    - Otherwise go to BEAT0.
  - BEAT0: drive word address W = addr word.
    - be = ((1<<size)-1) << off, truncated to 4 bits.
    - wdata = req_wdata << 8*off.
    - Hold the strobes until ext_mem_ready. On ready, capture rdata into lo.
    - Then go to BEAT1 if the access crosses, else to RESP.
  - BEAT1: drive W+1, wrapping modulo 2^EXT_ADDR_W.
    - be = ((1<<size)-1) >> (4-off).
    - wdata = req_wdata >> 8*(4-off).
    - On ready, capture rdata into hi, then go to RESP.
  - RESP: resp_valid = 1. All outputs are held stable until resp_ready, then go to IDLE.
- Load assembly:
  - raw = (lo >> 8*off) | (hi << 8*(4-off)). The hi term is used only when the access was split.
  - Extend raw from size: sign-extend for funct3[2] = 0, zero-extend for funct3[2] = 1.
  - Force the result to 0 when rd = 0.
- Bus strobes:
  - Exactly one of ext_mem_read or ext_mem_write is high in BEAT0/BEAT1.
  - Both are low in IDLE and RESP.
  - ext_mem_addr, ext_mem_wdata and ext_mem_be are constant for the whole beat.
  - They read 0 when no strobe is asserted.

## Timing
- Reset values: state = IDLE, req_ready = 1.
  - All of the following reset to 0: resp_valid, resp_data, resp_rd, resp_err, ext_mem_read, ext_mem_write, ext_mem_addr, ext_mem_wdata, ext_mem_be.
- Minimum latency:
  - Request accepted at edge 0.
  - BEAT0 strobes are high during cycle 1. With ready in cycle 1, resp_valid is high in cycle 2.
  - A split access adds one cycle per beat.
  - A rejected access shows resp_valid in cycle 1.
- Back-to-back requests: req_ready is 0 in every state except IDLE. The RESP→IDLE transition takes one cycle, so peak throughput is one access per 3 cycles.
- A beat stalls indefinitely while ext_mem_ready is low. ext_mem_ready outside BEAT0/BEAT1 is ignored.
- Asynchronous rst mid-beat: immediately drops all strobes and returns to IDLE. The partial transaction is abandoned and no response is issued.
- ext_mem_ready is sampled only while its own strobe is high. A ready in the cycle the state changes never counts twice.

## Test plan
- **lw, aligned:** addr 0x0010, ext rdata 0xDEADBEEF with ready in cycle 1 → ext_mem_addr 0x0004 and be 1111 in cycle 1; resp_data 0xDEADBEEF with resp_valid in cycle 2.
- **sb / lbu, sub-word lanes:**
  - sb at addr 0x0003 with wdata 0x000000A5 → be 1000, ext_mem_wdata 0xA5000000.
  - lb at 0x0003 with rdata 0x80000000 → resp_data 0xFFFFFF80.
  - lbu at the same address → resp_data 0x00000080.
- **Split lw:** addr 0x0006; beat 0 rdata 0x33221100, beat 1 rdata 0x77665544 → beats at word addresses 1 and 2, be 1100 then 0011; resp_data 0x55443322.
- **Split sh at wrap:** addr 0x3FFFF with wdata 0xBBAA → beat 0 at 0xFFFF, be 1000, wdata 0xAA000000; beat 1 at 0x0000, be 0001, wdata 0x000000BB.
- **MISALIGN_SPLIT = 0:** lw at 0x0006 → no strobe ever asserted; resp_err 1 and resp_data 0 in cycle 1. A following aligned lw completes normally.
- **Reset and rd = 0:**
  - Assert rst in BEAT1 with ready held low → strobes drop in the same cycle; state is IDLE with req_ready 1 and no resp_valid after release.
  - lw with rd = 0 → resp_data 0.
  - Resp_ready held low for 5 cycles → resp outputs stable and req_ready 0 throughout.

Source files
------------

// File: rtl/mem_access_unit.sv
// Multi-cycle MEM-stage load/store unit: one request at a time, byte-enabled word bus,
// optional two-beat split for boundary-crossing accesses, extended and tagged writeback.
module mem_access_unit #(
    parameter int ADDR_W         = 18,
    parameter int EXT_ADDR_W     = 16,
    parameter bit MISALIGN_SPLIT = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [4:0]            req_rd,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_data,
    output logic [4:0]            resp_rd,
    output logic                  resp_err,
    output logic [EXT_ADDR_W-1:0] ext_mem_addr,
    output logic [31:0]           ext_mem_wdata,
    output logic [3:0]            ext_mem_be,
    output logic                  ext_mem_read,
    output logic                  ext_mem_write,
    input  logic [31:0]           ext_mem_rdata,
    input  logic                  ext_mem_ready
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BEAT0 = 2'd1;
    localparam logic [1:0] S_BEAT1 = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    function automatic logic [2:0] norm_f3(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: norm_f3 = f3;
            default:                                norm_f3 = 3'b010;
        endcase
    endfunction

    function automatic logic [2:0] size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   size_of = 3'd1;
            2'b01:   size_of = 3'd2;
            default: size_of = 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] mask_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   mask_of = 4'b0001;
            2'b01:   mask_of = 4'b0011;
            default: mask_of = 4'b1111;
        endcase
    endfunction

    // Stores, rd==0 and errors all write back zero.
    function automatic logic [31:0] load_result(input logic [31:0] raw, input logic [2:0] f3,
                                                input logic st, input logic [4:0] rd);
        if (st || (rd == 5'd0)) begin
            load_result = 32'h0000_0000;
        end else begin
            case (f3[1:0])
                2'b00:   load_result = f3[2] ? {24'h00_0000, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
                2'b01:   load_result = f3[2] ? {16'h0000, raw[15:0]}    : {{16{raw[15]}}, raw[15:0]};
                default: load_result = raw;
            endcase
        end
    endfunction

    logic [1:0]            state_r;
    logic                  store_r;
    logic [2:0]            f3_r;
    logic [1:0]            off_r;
    logic                  cross_r;
    logic [31:0]           wdata_r;
    logic [4:0]            rd_r;
    logic [EXT_ADDR_W-1:0] waddr_r;
    logic [31:0]           lo_r;

    logic [2:0]            req_f3_s;
    logic [1:0]            req_off_s;
    logic                  req_cross_s;
    logic [3:0]            req_be0_s;
    logic [31:0]           req_wdata0_s;
    logic [3:0]            mask_s;
    logic [3:0]            be1_s;
    logic [4:0]            sh_lo_s;
    logic [5:0]            sh_hi_s;
    logic [31:0]           wdata1_s;
    logic [31:0]           raw0_s;
    logic [31:0]           raw1_s;

    assign req_f3_s     = norm_f3(req_funct3);
    assign req_off_s    = req_addr[1:0];
    assign req_cross_s  = ({2'b00, req_off_s} + {1'b0, size_of(req_f3_s)}) > 4'd4;
    assign req_be0_s    = mask_of(req_f3_s) << req_off_s;
    assign req_wdata0_s = req_wdata << {req_off_s, 3'b000};

    // Second-beat lanes come from the latched request; off is nonzero whenever a split happens.
    assign mask_s   = mask_of(f3_r);
    assign sh_lo_s  = {off_r, 3'b000};
    assign sh_hi_s  = 6'd32 - {1'b0, off_r, 3'b000};
    assign be1_s    = mask_s >> (3'd4 - {1'b0, off_r});
    assign wdata1_s = wdata_r >> sh_hi_s;
    assign raw0_s   = ext_mem_rdata >> sh_lo_s;
    assign raw1_s   = (lo_r >> sh_lo_s) | (ext_mem_rdata << sh_hi_s);

    // Control FSM with all bus and response outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= S_IDLE;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_data     <= 32'h0000_0000;
            resp_rd       <= 5'd0;
            resp_err      <= 1'b0;
            ext_mem_addr  <= '0;
            ext_mem_wdata <= 32'h0000_0000;
            ext_mem_be    <= 4'b0000;
            ext_mem_read  <= 1'b0;
            ext_mem_write <= 1'b0;
            store_r       <= 1'b0;
            f3_r          <= 3'b000;
            off_r         <= 2'b00;
            cross_r       <= 1'b0;
            wdata_r       <= 32'h0000_0000;
            rd_r          <= 5'd0;
            waddr_r       <= '0;
            lo_r          <= 32'h0000_0000;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        store_r   <= req_store;
                        f3_r      <= req_f3_s;
                        off_r     <= req_off_s;
                        cross_r   <= req_cross_s;
                        wdata_r   <= req_wdata;
                        rd_r      <= req_rd;
                        waddr_r   <= req_addr[EXT_ADDR_W+1:2];
                        if (req_cross_s && !MISALIGN_SPLIT) begin
                            state_r    <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_data  <= 32'h0000_0000;
                            resp_rd    <= req_rd;
                        end else begin
                            state_r       <= S_BEAT0;
                            ext_mem_read  <= ~req_store;
                            ext_mem_write <= req_store;
                            ext_mem_addr  <= req_addr[EXT_ADDR_W+1:2];
                            ext_mem_be    <= req_be0_s;
                            ext_mem_wdata <= req_wdata0_s;
                        end
                    end
                end
                S_BEAT0: begin
                    if (ext_mem_ready) begin
                        if (cross_r) begin
                            state_r       <= S_BEAT1;
                            lo_r          <= ext_mem_rdata;
                            ext_mem_addr  <= waddr_r + {{(EXT_ADDR_W-1){1'b0}}, 1'b1};
                            ext_mem_be    <= be1_s;
                            ext_mem_wdata <= wdata1_s;
                        end else begin
                            state_r       <= S_RESP;
                            ext_mem_read  <= 1'b0;
                            ext_mem_write <= 1'b0;
                            ext_mem_addr  <= '0;
                            ext_mem_be    <= 4'b0000;
                            ext_mem_wdata <= 32'h0000_0000;
                            resp_valid    <= 1'b1;
                            resp_err      <= 1'b0;
                            resp_rd       <= rd_r;
                            resp_data     <= load_result(raw0_s, f3_r, store_r, rd_r);
                        end
                    end
                end
                S_BEAT1: begin
                    if (ext_mem_ready) begin
                        state_r       <= S_RESP;
                        ext_mem_read  <= 1'b0;
                        ext_mem_write <= 1'b0;
                        ext_mem_addr  <= '0;
                        ext_mem_be    <= 4'b0000;
                        ext_mem_wdata <= 32'h0000_0000;
                        resp_valid    <= 1'b1;
                        resp_err      <= 1'b0;
                        resp_rd       <= rd_r;
                        resp_data     <= load_result(raw1_s, f3_r, store_r, rd_r);
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state_r    <= S_IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= S_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit: one split-enabled and one split-disabled instance.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    int          errors;
    int          checks;

    logic        req_valid, req_ready, req_store, resp_valid, resp_ready, resp_err;
    logic [2:0]  req_funct3;
    logic [17:0] req_addr;
    logic [31:0] req_wdata, resp_data, ext_mem_wdata, ext_mem_rdata;
    logic [4:0]  req_rd, resp_rd;
    logic [15:0] ext_mem_addr;
    logic [3:0]  ext_mem_be;
    logic        ext_mem_read, ext_mem_write, ext_mem_ready;

    logic        n_req_valid, n_req_ready, n_req_store, n_resp_valid, n_resp_ready, n_resp_err;
    logic [2:0]  n_req_funct3;
    logic [17:0] n_req_addr;
    logic [31:0] n_req_wdata, n_resp_data, n_ext_mem_wdata, n_ext_mem_rdata;
    logic [4:0]  n_req_rd, n_resp_rd;
    logic [15:0] n_ext_mem_addr;
    logic [3:0]  n_ext_mem_be;
    logic        n_ext_mem_read, n_ext_mem_write, n_ext_mem_ready;

    mem_access_unit #(.ADDR_W(18), .EXT_ADDR_W(16), .MISALIGN_SPLIT(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_rd(resp_rd), .resp_err(resp_err),
        .ext_mem_addr(ext_mem_addr), .ext_mem_wdata(ext_mem_wdata), .ext_mem_be(ext_mem_be),
        .ext_mem_read(ext_mem_read), .ext_mem_write(ext_mem_write),
        .ext_mem_rdata(ext_mem_rdata), .ext_mem_ready(ext_mem_ready)
    );

    mem_access_unit #(.ADDR_W(18), .EXT_ADDR_W(16), .MISALIGN_SPLIT(1'b0)) dut_ns (
        .clk(clk), .rst(rst),
        .req_valid(n_req_valid), .req_ready(n_req_ready), .req_store(n_req_store),
        .req_funct3(n_req_funct3), .req_addr(n_req_addr), .req_wdata(n_req_wdata), .req_rd(n_req_rd),
        .resp_valid(n_resp_valid), .resp_ready(n_resp_ready), .resp_data(n_resp_data),
        .resp_rd(n_resp_rd), .resp_err(n_resp_err),
        .ext_mem_addr(n_ext_mem_addr), .ext_mem_wdata(n_ext_mem_wdata), .ext_mem_be(n_ext_mem_be),
        .ext_mem_read(n_ext_mem_read), .ext_mem_write(n_ext_mem_write),
        .ext_mem_rdata(n_ext_mem_rdata), .ext_mem_ready(n_ext_mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus helpers: each starts and ends 1 time unit after a rising edge.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [17:0] a,
                         input logic [31:0] wd, input logic [4:0] rd);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic beat(input logic [31:0] rdata);
        ext_mem_rdata = rdata; ext_mem_ready = 1'b1;
        @(posedge clk); #1;
        ext_mem_ready = 1'b0;
    endtask

    task automatic take_resp;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        checks++; if ({resp_valid, resp_err, ext_mem_read, ext_mem_write} !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {resp_valid, resp_err, ext_mem_read, ext_mem_write}); end
        checks++; if ({resp_data, resp_rd, ext_mem_addr, ext_mem_wdata, ext_mem_be} !== 89'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", {resp_data, resp_rd, ext_mem_addr, ext_mem_wdata, ext_mem_be}); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_lw_aligned;
        issue(1'b0, 3'b010, 18'h00010, 32'h0, 5'd5);
        checks++; if ({ext_mem_read, ext_mem_write} !== 2'b10) begin errors++; $display("FAIL lw_strobes got=%b exp=10", {ext_mem_read, ext_mem_write}); end
        checks++; if (ext_mem_addr !== 16'h0004) begin errors++; $display("FAIL lw_addr got=%h exp=0004", ext_mem_addr); end
        checks++; if (ext_mem_be !== 4'b1111) begin errors++; $display("FAIL lw_be got=%b exp=1111", ext_mem_be); end
        checks++; if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL lw_busy got=%b%b exp=00", req_ready, resp_valid); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ext_mem_read !== 1'b1 || ext_mem_addr !== 16'h0004) begin errors++; $display("FAIL lw_stall got=%b/%h exp=1/0004", ext_mem_read, ext_mem_addr); end
        beat(32'hDEADBEEF);
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin errors++; $display("FAIL lw_valid got=%b%b exp=10", resp_valid, resp_err); end
        checks++; if (resp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got=%h exp=deadbeef", resp_data); end
        checks++; if (resp_rd !== 5'd5) begin errors++; $display("FAIL lw_rd got=%0d exp=5", resp_rd); end
        checks++; if ({ext_mem_read, ext_mem_write, ext_mem_be} !== 6'd0) begin errors++; $display("FAIL lw_idle_bus got=%b exp=0", {ext_mem_read, ext_mem_write, ext_mem_be}); end
        take_resp();
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL lw_back_idle got=%b%b exp=10", req_ready, resp_valid); end
    endtask

    task automatic test_sub_word;
        issue(1'b1, 3'b000, 18'h00003, 32'h000000A5, 5'd1);
        checks++; if ({ext_mem_read, ext_mem_write} !== 2'b01) begin errors++; $display("FAIL sb_strobes got=%b exp=01", {ext_mem_read, ext_mem_write}); end
        checks++; if (ext_mem_be !== 4'b1000) begin errors++; $display("FAIL sb_be got=%b exp=1000", ext_mem_be); end
        checks++; if (ext_mem_wdata !== 32'hA5000000) begin errors++; $display("FAIL sb_wdata got=%h exp=a5000000", ext_mem_wdata); end
        beat(32'hFFFFFFFF);
        checks++; if (resp_valid !== 1'b1 || resp_data !== 32'h0) begin errors++; $display("FAIL sb_resp got=%b/%h exp=1/0", resp_valid, resp_data); end
        take_resp();
        issue(1'b0, 3'b000, 18'h00003, 32'h0, 5'd2);
        beat(32'h80000000);
        checks++; if (resp_data !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data got=%h exp=ffffff80", resp_data); end
        take_resp();
        issue(1'b0, 3'b100, 18'h00003, 32'h0, 5'd2);
        beat(32'h80000000);
        checks++; if (resp_data !== 32'h00000080) begin errors++; $display("FAIL lbu_data got=%h exp=00000080", resp_data); end
        take_resp();
    endtask

    task automatic test_split_lw;
        issue(1'b0, 3'b010, 18'h00006, 32'h0, 5'd7);
        checks++; if (ext_mem_addr !== 16'h0001 || ext_mem_be !== 4'b1100) begin errors++; $display("FAIL split_b0 got=%h/%b exp=0001/1100", ext_mem_addr, ext_mem_be); end
        beat(32'h33221100);
        checks++; if (ext_mem_addr !== 16'h0002 || ext_mem_be !== 4'b0011) begin errors++; $display("FAIL split_b1 got=%h/%b exp=0002/0011", ext_mem_addr, ext_mem_be); end
        checks++; if (ext_mem_read !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL split_b1_state got=%b%b exp=10", ext_mem_read, resp_valid); end
        beat(32'h77665544);
        checks++; if (resp_valid !== 1'b1 || resp_data !== 32'h55443322) begin errors++; $display("FAIL split_data got=%b/%h exp=1/55443322", resp_valid, resp_data); end
        take_resp();
    endtask

    task automatic test_split_sh_wrap;
        issue(1'b1, 3'b001, 18'h3FFFF, 32'h0000BBAA, 5'd0);
        checks++; if (ext_mem_addr !== 16'hFFFF || ext_mem_be !== 4'b1000) begin errors++; $display("FAIL wrap_b0 got=%h/%b exp=ffff/1000", ext_mem_addr, ext_mem_be); end
        checks++; if (ext_mem_wdata !== 32'hAA000000 || ext_mem_write !== 1'b1) begin errors++; $display("FAIL wrap_b0_wdata got=%h/%b exp=aa000000/1", ext_mem_wdata, ext_mem_write); end
        beat(32'h0);
        checks++; if (ext_mem_addr !== 16'h0000 || ext_mem_be !== 4'b0001) begin errors++; $display("FAIL wrap_b1 got=%h/%b exp=0000/0001", ext_mem_addr, ext_mem_be); end
        checks++; if (ext_mem_wdata !== 32'h000000BB) begin errors++; $display("FAIL wrap_b1_wdata got=%h exp=000000bb", ext_mem_wdata); end
        beat(32'h0);
        checks++; if (resp_valid !== 1'b1 || ext_mem_write !== 1'b0) begin errors++; $display("FAIL wrap_done got=%b%b exp=10", resp_valid, ext_mem_write); end
        take_resp();
    endtask

    task automatic test_no_split;
        n_req_valid = 1'b1; n_req_store = 1'b0; n_req_funct3 = 3'b010; n_req_addr = 18'h00006; n_req_rd = 5'd4;
        @(posedge clk); #1;
        n_req_valid = 1'b0;
        checks++; if ({n_ext_mem_read, n_ext_mem_write} !== 2'b00) begin errors++; $display("FAIL ns_strobes got=%b exp=00", {n_ext_mem_read, n_ext_mem_write}); end
        checks++; if (n_resp_valid !== 1'b1 || n_resp_err !== 1'b1) begin errors++; $display("FAIL ns_err got=%b%b exp=11", n_resp_valid, n_resp_err); end
        checks++; if (n_resp_data !== 32'h0 || n_req_ready !== 1'b0) begin errors++; $display("FAIL ns_data got=%h/%b exp=0/0", n_resp_data, n_req_ready); end
        n_resp_ready = 1'b1; @(posedge clk); #1; n_resp_ready = 1'b0;
        n_req_valid = 1'b1; n_req_addr = 18'h00010; n_req_rd = 5'd3;
        @(posedge clk); #1;
        n_req_valid = 1'b0;
        checks++; if (n_ext_mem_read !== 1'b1 || n_ext_mem_addr !== 16'h0004) begin errors++; $display("FAIL ns_follow_bus got=%b/%h exp=1/0004", n_ext_mem_read, n_ext_mem_addr); end
        n_ext_mem_rdata = 32'h0000ABCD; n_ext_mem_ready = 1'b1;
        @(posedge clk); #1;
        n_ext_mem_ready = 1'b0;
        checks++; if (n_resp_valid !== 1'b1 || n_resp_err !== 1'b0 || n_resp_data !== 32'h0000ABCD) begin errors++; $display("FAIL ns_follow_resp got=%b%b/%h exp=10/0000abcd", n_resp_valid, n_resp_err, n_resp_data); end
        n_resp_ready = 1'b1; @(posedge clk); #1; n_resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_beat;
        issue(1'b0, 3'b010, 18'h00006, 32'h0, 5'd6);
        beat(32'h0);
        @(posedge clk); #1;
        checks++; if (ext_mem_read !== 1'b1 || ext_mem_addr !== 16'h0002) begin errors++; $display("FAIL rst_in_b1 got=%b/%h exp=1/0002", ext_mem_read, ext_mem_addr); end
        rst = 1'b1;
        #1;
        checks++; if ({ext_mem_read, ext_mem_write, ext_mem_be} !== 6'd0 || ext_mem_addr !== 16'h0) begin errors++; $display("FAIL rst_drop got=%b/%h exp=0/0", {ext_mem_read, ext_mem_write, ext_mem_be}, ext_mem_addr); end
        #2;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || ext_mem_read !== 1'b0) begin errors++; $display("FAIL rst_after got=%b%b%b exp=100", req_ready, resp_valid, ext_mem_read); end
    endtask

    task automatic test_rd_zero;
        issue(1'b0, 3'b010, 18'h00010, 32'h0, 5'd0);
        beat(32'hFFFFFFFF);
        checks++; if (resp_valid !== 1'b1 || resp_data !== 32'h0 || resp_rd !== 5'd0) begin errors++; $display("FAIL rd0 got=%b/%h/%0d exp=1/0/0", resp_valid, resp_data, resp_rd); end
        take_resp();
    endtask

    task automatic test_back_pressure;
        issue(1'b0, 3'b001, 18'h00002, 32'h0, 5'd9);
        beat(32'h80010000);
        for (int i = 0; i < 5; i++) begin
            checks++; if (resp_valid !== 1'b1 || resp_data !== 32'hFFFF8001 || resp_rd !== 5'd9 || req_ready !== 1'b0) begin errors++; $display("FAIL bp_hold[%0d] got=%b/%h/%0d/%b exp=1/ffff8001/9/0", i, resp_valid, resp_data, resp_rd, req_ready); end
            @(posedge clk); #1;
        end
        take_resp();
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL bp_release got=%b%b exp=10", req_ready, resp_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        errors = 0; checks = 0;
        req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000; req_addr = 18'h0; req_wdata = 32'h0; req_rd = 5'd0;
        resp_ready = 1'b0; ext_mem_rdata = 32'h0; ext_mem_ready = 1'b0;
        n_req_valid = 1'b0; n_req_store = 1'b0; n_req_funct3 = 3'b000; n_req_addr = 18'h0; n_req_wdata = 32'h0; n_req_rd = 5'd0;
        n_resp_ready = 1'b0; n_ext_mem_rdata = 32'h0; n_ext_mem_ready = 1'b0;
        test_reset();
        test_lw_aligned();
        test_sub_word();
        test_split_lw();
        test_split_sh_wrap();
        test_no_split();
        test_reset_mid_beat();
        test_rd_zero();
        test_back_pressure();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
